// File: rtl/latency_memory.sv
// Word-addressed memory with a fixed multi-cycle access latency and a single-outstanding
// valid/ready request handshake, shared by instruction fetch and data access.
module latency_memory #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              ack,
    output logic              busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;
    logic                    complete;
    logic                    cap_wr;
    logic [DEPTH_LOG2-1:0]   cap_addr;
    logic [DATA_W-1:0]       cap_data;
    logic [DATA_W-1:0]       mem [DEPTH];

    // Upper address bits alias onto the array; this reduction only marks them as deliberately dropped.
    logic addr_unused;
    assign addr_unused = ^addr;

    assign req_ready = (state == IDLE);
    assign busy      = (state == WAIT);
    assign accept    = (state == IDLE) && req_valid;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request fields are held for the whole wait so the bus is free to change underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_wr   <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
        end else if (accept) begin
            cap_wr   <= wr;
            cap_addr <= addr[DEPTH_LOG2-1:0];
            cap_data <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            ack        <= complete;
            data_valid <= complete && !cap_wr;
            if (complete && !cap_wr) begin
                data_out <= mem[cap_addr];
            end
        end
    end

    // The array has no reset; a reset in WAIT forces IDLE, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (complete && cap_wr) begin
            mem[cap_addr] <= cap_data;
        end
    end

endmodule

// File: tb/tb_latency_memory.sv
// Self-checking bench for latency_memory: two instances (LATENCY=4 and LATENCY=1) checked
// against directed expectations and an associative-array memory model.
module tb_latency_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv4 = 1'b0;
    logic        rv1 = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;

    logic        ready4, dv4, ack4, busy4;
    logic [15:0] dout4;
    logic        ready1, dv1, ack1, busy1;
    logic [15:0] dout1;

    int total = 0;
    int bad = 0;
    bit sel1 = 1'b0;

    logic [15:0] model4 [int];
    logic [15:0] model1 [int];

    logic        ready_s, dv_s, ack_s, busy_s;
    logic [15:0] dout_s;
    assign ready_s = sel1 ? ready1 : ready4;
    assign dv_s    = sel1 ? dv1    : dv4;
    assign ack_s   = sel1 ? ack1   : ack4;
    assign busy_s  = sel1 ? busy1  : busy4;
    assign dout_s  = sel1 ? dout1  : dout4;

    always #5 clk = ~clk;

    latency_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(ready4), .wr(wr),
        .addr(addr), .data_in(data_in), .data_out(dout4), .data_valid(dv4),
        .ack(ack4), .busy(busy4)
    );

    latency_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(ready1), .wr(wr),
        .addr(addr), .data_in(data_in), .data_out(dout1), .data_valid(dv1),
        .ack(ack1), .busy(busy1)
    );

    // Issues one request and records what the selected instance shows afterwards.
    task automatic do_op(input bit use1, input bit w, input logic [15:0] a, input logic [15:0] d,
                         input bit toggle, output int ack_cycle, output int ack_pulses,
                         output int busy_cycles, output logic dv_at_ack,
                         output logic [15:0] dout_at_ack);
        int lat;
        lat = use1 ? 1 : 4;
        sel1 = use1;
        wr = w;
        addr = a;
        data_in = d;
        if (use1) rv1 = 1'b1; else rv4 = 1'b1;
        @(posedge clk); #1;
        ack_cycle = -1;
        ack_pulses = 0;
        busy_cycles = 0;
        dv_at_ack = 1'b0;
        dout_at_ack = '0;
        for (int k = 1; k <= lat + 2; k++) begin
            bit v;
            v = (toggle && k <= lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (use1) rv1 = v; else rv4 = v;
            wr = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            data_in = 16'($urandom);
            if (busy_s) busy_cycles++;
            @(posedge clk); #1;
            if (ack_s) begin
                ack_pulses++;
                if (ack_cycle < 0) begin
                    ack_cycle = k;
                    dv_at_ack = dv_s;
                    dout_at_ack = dout_s;
                end
            end
        end
        rv1 = 1'b0;
        rv4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready4 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready4 got=%b exp=1", ready4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy4 got=%b exp=0", busy4); end
        total++; if (ack4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack4 got=%b exp=0", ack4); end
        total++; if (dv4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dv4 got=%b exp=0", dv4); end
        total++; if (dout4 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dout4 got=%h exp=0000", dout4); end
        total++; if (ready1 !== 1'b1 || busy1 !== 1'b0 || dout1 !== 16'h0000) begin
            bad++; $display("[TB] FAIL reset_l1 got ready=%b busy=%b dout=%h exp 1/0/0000", ready1, busy1, dout1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int ac, ap, bc;
        logic dv;
        logic [15:0] dq;
        do_op(0, 1'b1, 16'h0010, 16'hBEEF, 0, ac, ap, bc, dv, dq);
        total++; if (ac !== 4) begin bad++; $display("[TB] FAIL wr_ack_cycle got=%0d exp=4", ac); end
        total++; if (ap !== 1) begin bad++; $display("[TB] FAIL wr_ack_pulses got=%0d exp=1", ap); end
        total++; if (dv !== 1'b0) begin bad++; $display("[TB] FAIL wr_dv got=%b exp=0", dv); end
        total++; if (bc !== 4) begin bad++; $display("[TB] FAIL wr_busy_cycles got=%0d exp=4", bc); end
        do_op(0, 1'b0, 16'h0010, 16'h0000, 0, ac, ap, bc, dv, dq);
        total++; if (ac !== 4) begin bad++; $display("[TB] FAIL rd_ack_cycle got=%0d exp=4", ac); end
        total++; if (dv !== 1'b1) begin bad++; $display("[TB] FAIL rd_dv got=%b exp=1", dv); end
        total++; if (dq !== 16'hBEEF) begin bad++; $display("[TB] FAIL rd_data got=%h exp=beef", dq); end
        total++; if (bc !== 4) begin bad++; $display("[TB] FAIL rd_busy_cycles got=%0d exp=4", bc); end
        total++; if (dout4 !== 16'hBEEF) begin bad++; $display("[TB] FAIL rd_hold got=%h exp=beef", dout4); end
    endtask

    task automatic test_back_to_back();
        int ac, ap, bc;
        logic dv;
        logic [15:0] dq;
        int ack_at[$];
        logic [15:0] seq[$];
        int dv_cnt;
        int nxt;
        for (int i = 1; i <= 3; i++) begin
            do_op(0, 1'b1, 16'(i), 16'(i), 0, ac, ap, bc, dv, dq);
        end
        dv_cnt = 0;
        nxt = 2;
        sel1 = 1'b0;
        wr = 1'b0;
        addr = 16'd1;
        rv4 = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (dv4) dv_cnt++;
            if (ack4) begin
                ack_at.push_back(cyc);
                seq.push_back(dout4);
                if (nxt <= 3) begin
                    addr = 16'(nxt);
                    nxt++;
                end else begin
                    rv4 = 1'b0;
                end
            end
        end
        rv4 = 1'b0;
        total++; if (ack_at.size() !== 3) begin bad++; $display("[TB] FAIL b2b_acks got=%0d exp=3", ack_at.size()); end
        total++; if (dv_cnt !== 3) begin bad++; $display("[TB] FAIL b2b_dv_cycles got=%0d exp=3", dv_cnt); end
        if (ack_at.size() == 3) begin
            total++; if (ack_at[0] !== 5) begin bad++; $display("[TB] FAIL b2b_first_ack got=%0d exp=5", ack_at[0]); end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (seq[i] !== 16'(i + 1)) begin bad++; $display("[TB] FAIL b2b_data%0d got=%h exp=%h", i, seq[i], 16'(i + 1)); end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (ack_at[i] - ack_at[i-1] !== 5) begin
                    bad++; $display("[TB] FAIL b2b_spacing%0d got=%0d exp=5", i, ack_at[i] - ack_at[i-1]);
                end
            end
        end
    endtask

    task automatic test_alias();
        int ac, ap, bc;
        logic dv;
        logic [15:0] dq;
        do_op(0, 1'b1, 16'h0405, 16'h1234, 0, ac, ap, bc, dv, dq);
        do_op(0, 1'b0, 16'h0005, 16'h0000, 0, ac, ap, bc, dv, dq);
        total++; if (dq !== 16'h1234) begin bad++; $display("[TB] FAIL alias_data got=%h exp=1234", dq); end
    endtask

    task automatic test_ignored_inputs();
        int ac, ap, bc;
        logic dv;
        logic [15:0] dq;
        do_op(0, 1'b1, 16'h0033, 16'h5A5A, 1, ac, ap, bc, dv, dq);
        total++; if (ap !== 1 || bc !== 4) begin bad++; $display("[TB] FAIL ignore_wr got acks=%0d busy=%0d exp 1/4", ap, bc); end
        do_op(0, 1'b0, 16'h0033, 16'h0000, 1, ac, ap, bc, dv, dq);
        total++; if (ap !== 1 || bc !== 4) begin bad++; $display("[TB] FAIL ignore_rd got acks=%0d busy=%0d exp 1/4", ap, bc); end
        total++; if (dq !== 16'h5A5A) begin bad++; $display("[TB] FAIL ignore_data got=%h exp=5a5a", dq); end
    endtask

    task automatic test_reset_mid_write();
        int ac, ap, bc;
        int ack_seen;
        logic dv;
        logic [15:0] dq;
        do_op(0, 1'b1, 16'h0007, 16'h5555, 0, ac, ap, bc, dv, dq);
        sel1 = 1'b0;
        wr = 1'b1;
        addr = 16'h0007;
        data_in = 16'hAAAA;
        rv4 = 1'b1;
        @(posedge clk); #1;
        rv4 = 1'b0;
        ack_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack4) ack_seen++;
        end
        rst_n = 1'b0;
        #1;
        total++; if (ready4 !== 1'b1 || busy4 !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_abort got ready=%b busy=%b exp 1/0", ready4, busy4);
        end
        total++; if (dout4 !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_dout got=%h exp=0000", dout4); end
        repeat (2) begin
            @(posedge clk); #1;
            if (ack4 || dv4) ack_seen++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (ack4) ack_seen++;
        total++; if (ack_seen !== 0) begin bad++; $display("[TB] FAIL midrst_ack got=%0d exp=0", ack_seen); end
        do_op(0, 1'b0, 16'h0007, 16'h0000, 0, ac, ap, bc, dv, dq);
        total++; if (dq !== 16'h5555) begin bad++; $display("[TB] FAIL midrst_data got=%h exp=5555", dq); end
    endtask

    task automatic test_latency1();
        int ac, ap, bc;
        logic dv;
        logic [15:0] dq;
        do_op(1, 1'b1, 16'h0007, 16'hAAAA, 0, ac, ap, bc, dv, dq);
        total++; if (ac !== 1 || dv !== 1'b0) begin bad++; $display("[TB] FAIL l1_wr got ack_cycle=%0d dv=%b exp 1/0", ac, dv); end
        do_op(1, 1'b0, 16'h0007, 16'h0000, 0, ac, ap, bc, dv, dq);
        total++; if (ac !== 1 || bc !== 1) begin bad++; $display("[TB] FAIL l1_rd_timing got ack=%0d busy=%0d exp 1/1", ac, bc); end
        total++; if (dq !== 16'hAAAA || dv !== 1'b1) begin bad++; $display("[TB] FAIL l1_rd_data got=%h dv=%b exp aaaa/1", dq, dv); end
    endtask

    task automatic test_random(input bit use1);
        int ac, ap, bc, lat, key;
        bit w;
        logic dv;
        logic [15:0] a, d, dq, exp_d;
        bit known;
        lat = use1 ? 1 : 4;
        for (int i = 0; i < 24; i++) begin
            w = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            a = (16'($urandom) & 16'hFC00) | 16'($urandom_range(0, 7));
            d = 16'($urandom);
            key = int'(a[9:0]);
            do_op(use1, w, a, d, 1'($urandom_range(0, 1)), ac, ap, bc, dv, dq);
            total++;
            if (ac !== lat || ap !== 1 || bc !== lat) begin
                bad++; $display("[TB] FAIL rand_timing l%0d op%0d got ack=%0d pulses=%0d busy=%0d exp %0d/1/%0d",
                                lat, i, ac, ap, bc, lat, lat);
            end
            total++;
            if (dv !== !w) begin bad++; $display("[TB] FAIL rand_dv l%0d op%0d got=%b exp=%b", lat, i, dv, !w); end
            known = 1'b0;
            exp_d = '0;
            if (use1) begin
                if (w) model1[key] = d;
                else if (model1.exists(key)) begin known = 1'b1; exp_d = model1[key]; end
            end else begin
                if (w) model4[key] = d;
                else if (model4.exists(key)) begin known = 1'b1; exp_d = model4[key]; end
            end
            if (known) begin
                total++;
                if (dq !== exp_d) begin bad++; $display("[TB] FAIL rand_data l%0d op%0d addr=%h got=%h exp=%h", lat, i, a, dq, exp_d); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_ignored_inputs();
        test_reset_mid_write();
        test_latency1();
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/latency_memory.md
# latency_memory

Parametrised, word-addressed memory with a configurable fixed access latency and a valid/ready request handshake. It succeeds the single-cycle data and instruction memories for the multi-cycle processor phase. The CPU issues one request, stalls on `busy`, and resumes on `ack`. It is used for both instruction fetch and data access.

## Interface
- `DATA_W`, default 16: word width in bits.
- `ADDR_W`, default 16: width of the `addr` port.
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 words. Requires 1 ≤ DEPTH_LOG2 ≤ ADDR_W.
- `LATENCY`, default 4: cycles from request acceptance to completion. Requires LATENCY ≥ 1.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present this cycle.
- `req_ready`  out  1  block can accept a request this cycle.
- `wr`  in  1  1 = write, 0 = read; sampled at acceptance.
- `addr`  in  ADDR_W  word address; sampled at acceptance.
- `data_in`  in  DATA_W  write data; sampled at acceptance.
- `data_out`  out  DATA_W  result of the most recent completed read.
- `data_valid`  out  1  one-cycle pulse: read data on `data_out` is new.
- `ack`  out  1  one-cycle pulse: request (read or write) completed.
- `busy`  out  1  request in flight; equals ~req_ready.

## Operation
- **Two-state FSM: IDLE, WAIT.** A down-counter `cnt` has width max(1, clog2(LATENCY)).
- **IDLE**
  - `req_ready`=1, `busy`=0.
  - On an edge with `req_valid`=1: capture `wr`, `addr[DEPTH_LOG2-1:0]`, `data_in`; load `cnt`=LATENCY-1; go to WAIT.
- **WAIT**
  - `req_ready`=0, `busy`=1.
  - `req_valid`, `wr`, `addr`, `data_in` are ignored.
  - Each edge with `cnt`≠0: decrement `cnt`.
  - Edge with `cnt`=0: perform the access and go to IDLE.
    - Write: commit the captured data to the array.
    - Read: register the array word into `data_out`.
- **Address wrap:** upper bits `addr[ADDR_W-1:DEPTH_LOG2]` are ignored; addresses alias modulo 2^DEPTH_LOG2.
- **Completion outputs:**
  - `ack` pulses high for exactly the one cycle after every completion edge.
  - `data_valid` pulses in the same cycle only for reads.
  - `data_out` holds its value until the next read completes; writes never change it.
- **Ordering:** strictly one outstanding request. A write always commits before the next request can be accepted, so read-after-write to the same address returns the new data.
- **Array contents:** not reset. A read of a never-written location returns an undefined value (X in simulation).

## Timing
- **Reset values:** `req_ready`=1, `busy`=0, `ack`=0, `data_valid`=0, `data_out`=0, state IDLE, `cnt`=0.
- **Latency:** request accepted at edge E0. Access performed at edge E_LATENCY. `ack`/`data_valid` are high during the cycle between E_LATENCY and E_LATENCY+1.
  - LATENCY=1 gives the pulse the cycle after acceptance.
- **Ready recovery:** `req_ready` returns to 1 in the same cycle `ack` is high.
  - A request presented in that cycle is accepted at E_LATENCY+1.
  - Sustained throughput is therefore one request per LATENCY+1 cycles.
- **Handshake:** acceptance occurs only when `req_valid`·`req_ready`=1 at an edge. The requester need not hold `req_valid` after acceptance.
- **Reset mid-operation:** assertion of `rst_n`=0 in WAIT aborts the request immediately (asynchronously).
  - No write is committed and no `ack` or `data_valid` pulse occurs.
  - All outputs go to their reset values.
  - After release, the block is in IDLE.
- **Outputs are registered:** no combinational path from inputs to outputs. `req_ready` and `busy` derive from state only.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles. Required: `req_ready`=1, `busy`=0, `ack`=0, `data_valid`=0, `data_out`=0x0000.
- **Write then read, LATENCY=4:** write 0xBEEF to addr 0x0010, then read addr 0x0010.
  - Write `ack` is high exactly 4 cycles after acceptance, with `data_valid`=0.
  - Read `data_valid`=`ack`=1 exactly 4 cycles after its acceptance, with `data_out`=0xBEEF.
  - `busy`=1 for cycles 1–4 after each acceptance.
- **Back-to-back:** hold `req_valid`=1 over 3 reads of pre-written 0x0001/0x0002/0x0003 at addrs 1–3.
  - Acceptances are 5 cycles apart.
  - `data_out` sequence is 0x0001, 0x0002, 0x0003, each with a single-cycle `data_valid` pulse.
- **Alias, DEPTH_LOG2=10:** write 0x1234 to addr 0x0405, then read addr 0x0005. Required: `data_out`=0x1234.
- **Ignored inputs in WAIT:** toggle `req_valid`/`wr`/`addr` while `busy`=1. Required: no extra acceptance and the original request completes unchanged.
- **Reset mid-write:** write 0xAAAA to addr 7 over an address pre-written with 0x5555. Pulse `rst_n` low 2 cycles after acceptance, then read addr 7.
  - Required: no `ack` before the reset.
  - Read returns 0x5555.
  - Repeat the write/read sequence with LATENCY=1.
